// File: rtl/sig_pkg.sv
// Shared definitions for the DAC serializer slice.
//   serializer_state_t : FSM state encoding (idle / shifting / latch gap)
//   FRAME_W            : width of the completed-frame counter
package sig_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } serializer_state_t;

endpackage

// File: rtl/dac_serializer_sclk_divider.sv
// Serial-clock divider for the DAC serializer.
// Counts clk cycles 0..CLK_DIV-1 and asserts tick during the last cycle of
// each serial-clock half-period.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear, asserted by the FSM on state entry
//   tick : high in the last cycle of a half-period
module sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_ZERO = DW'(0);

  logic [DW-1:0] div_cnt_r;

  // With CLK_DIV=1 the counter is pinned at 0, so tick stays high every cycle.
  assign tick = (div_cnt_r == DIV_MAX);

  // Half-period counter: wraps at CLK_DIV-1 or when the FSM clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= DIV_ZERO;
    end else if (clr || tick) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// DAC serializer: accepts one WIDTH-bit sample per valid/ready handshake and
// shifts it MSB-first onto a 3-wire SPI-style DAC link.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   din    : sample from the generator
//   valid  : din holds a sample
//   ready  : high only while idle; drives the generator's enable
//   sclk   : serial clock to the DAC (data is stable around its rising edge)
//   sdata  : serial data, MSB first
//   cs_n   : active-low DAC chip select
//   frames : count of completed frames, wraps modulo 2^16
module dac_serializer
  import sig_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               valid,
  output logic               ready,
  output logic               sclk,
  output logic               sdata,
  output logic               cs_n,
  output logic [FRAME_W-1:0] frames
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0]      BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0]      BIT_ONE   = BW'(1);
  localparam logic [BW-1:0]      BIT_ZERO  = BW'(0);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  serializer_state_t  state_r, state_next_s;
  logic [WIDTH-1:0]   shreg_r, shreg_next_s;
  logic [BW-1:0]      bit_cnt_r, bit_cnt_next_s;
  logic               sclk_r, sclk_next_s;
  logic [FRAME_W-1:0] frames_r, frames_next_s;
  logic               ready_r, ready_next_s;
  logic               cs_n_r, cs_n_next_s;
  logic               sdata_r, sdata_next_s;
  logic               div_clr_s;
  logic               tick_s;

  sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (div_clr_s),
    .tick(tick_s)
  );

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_next_s   = state_r;
    shreg_next_s   = shreg_r;
    bit_cnt_next_s = bit_cnt_r;
    sclk_next_s    = sclk_r;
    frames_next_s  = frames_r;

    case (state_r)
      S_IDLE: begin
        sclk_next_s = 1'b0;
        if (valid) begin
          state_next_s   = S_SHIFT;
          shreg_next_s   = din;
          bit_cnt_next_s = BIT_ZERO;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (tick_s) begin
          if (sclk_r) begin
            // Falling sclk: present the next bit and count the finished one.
            sclk_next_s    = 1'b0;
            shreg_next_s   = {shreg_r[WIDTH-2:0], 1'b0};
            bit_cnt_next_s = bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == BIT_LAST) begin
              state_next_s = S_LATCH;
            end else begin
              state_next_s = S_SHIFT;
            end
          end else begin
            sclk_next_s = 1'b1;
          end
        end else begin
          sclk_next_s = sclk_r;
        end
      end
      S_LATCH: begin
        sclk_next_s = 1'b0;
        if (tick_s) begin
          state_next_s  = S_IDLE;
          frames_next_s = frames_r + FRAME_ONE;
        end else begin
          state_next_s = S_LATCH;
        end
      end
      default: begin
        state_next_s = S_IDLE;
        sclk_next_s  = 1'b0;
      end
    endcase

    // The divider restarts on every state entry and is parked while idle.
    div_clr_s    = (state_next_s != state_r) || (state_r == S_IDLE);
    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    ready_next_s = (state_next_s == S_IDLE);
    cs_n_next_s  = (state_next_s != S_SHIFT);
    sdata_next_s = (state_next_s == S_SHIFT) ? shreg_next_s[WIDTH-1] : 1'b0;
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= BIT_ZERO;
      sclk_r    <= 1'b0;
      frames_r  <= '0;
      ready_r   <= 1'b1;
      cs_n_r    <= 1'b1;
      sdata_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shreg_r   <= shreg_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      sclk_r    <= sclk_next_s;
      frames_r  <= frames_next_s;
      ready_r   <= ready_next_s;
      cs_n_r    <= cs_n_next_s;
      sdata_r   <= sdata_next_s;
    end
  end

  assign ready  = ready_r;
  assign sclk   = sclk_r;
  assign sdata  = sdata_r;
  assign cs_n   = cs_n_r;
  assign frames = frames_r;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer. A cycle-budget reference model
// (busy countdown from the frame-length formula) predicts every output each
// cycle; a DAC model reassembles words from rising sclk. A second instance
// covers WIDTH=4, CLK_DIV=1.
module tb_dac_serializer;

  localparam int W   = 8;
  localparam int C   = 4;
  localparam int TOT = 2 * W * C + C;   // busy cycles after an accepting edge

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         valid;
  logic         ready, sclk, sdata, cs_n;
  logic [15:0]  frames;

  logic [3:0]   din_s;
  logic         valid_s;
  logic         ready_s, sclk_s, sdata_s, cs_n_s;
  logic [15:0]  frames_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  int           m_busy;
  int           m_frames;
  logic [W-1:0] m_cur;

  // DAC monitor state
  logic [W-1:0] mon_word;
  int           mon_bits, mon_low, last_fall;
  logic         prev_sclk, prev_cs_n, have_fall, bb_mode;

  dac_serializer #(.WIDTH(W), .CLK_DIV(C)) u_dut (
    .clk(clk), .rst(rst), .din(din), .valid(valid), .ready(ready),
    .sclk(sclk), .sdata(sdata), .cs_n(cs_n), .frames(frames)
  );

  dac_serializer #(.WIDTH(4), .CLK_DIV(1)) u_small (
    .clk(clk), .rst(rst), .din(din_s), .valid(valid_s), .ready(ready_s),
    .sclk(sclk_s), .sdata(sdata_s), .cs_n(cs_n_s), .frames(frames_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted sample keeps the block busy for TOT cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 0;
      m_frames <= 0;
      m_cur    <= '0;
    end else if (m_busy == 0) begin
      if (valid) begin
        m_busy <= TOT;
        m_cur  <= din;
      end
    end else begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_frames <= (m_frames + 1) % 65536;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison of the main instance against the model.
  task automatic compare_main();
    int  e;
    int  idx;
    logic shifting;
    logic exp_sclk, exp_sdata;
    e        = TOT - m_busy;
    shifting = (m_busy > C);
    exp_sclk = shifting && (((e / C) % 2) == 1);
    idx      = W - 1 - (e / (2 * C));
    exp_sdata = (shifting && idx >= 0) ? m_cur[idx] : 1'b0;
    check("ready",  ready,  (m_busy == 0));
    check("cs_n",   cs_n,   !shifting);
    check("sclk",   sclk,   exp_sclk);
    check("sdata",  sdata,  exp_sdata);
    check("frames", frames, m_frames);
  endtask

  // DAC-side model: sample sdata on rising sclk while selected.
  task automatic monitor_main();
    if (rst) begin
      prev_cs_n = 1'b1;
      prev_sclk = 1'b0;
      have_fall = 1'b0;
      mon_bits  = 0;
      mon_low   = 0;
      mon_word  = '0;
    end else begin
      if (!cs_n) begin
        if (prev_cs_n) begin
          if (bb_mode && have_fall) check("bb_spacing", cyc - last_fall, TOT + 1);
          last_fall = cyc;
          have_fall = bb_mode;
          mon_word  = '0;
          mon_bits  = 0;
          mon_low   = 0;
        end
        mon_low++;
        if (sclk && !prev_sclk) begin
          mon_word = {mon_word[W-2:0], sdata};
          mon_bits++;
        end
      end else if (!prev_cs_n) begin
        check("dac_word",   mon_word, m_cur);
        check("dac_bits",   mon_bits, W);
        check("cs_low_len", mon_low,  2 * W * C);
      end
      prev_cs_n = cs_n;
      prev_sclk = sclk;
    end
  endtask

  // One cycle: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    compare_main();
    monitor_main();
    @(posedge clk);
    #1;
  endtask

  // Wait until ready returns; returns cycles waited (capped at the bound).
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_valid(input logic [W-1:0] v);
    din   = v;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  initial begin : stim
    int n;
    int bits;
    int cs_low, latch_len, ready_at, nb;
    logic prev_s;
    logic [W-1:0] vals [4];
    vals[0] = 8'h00; vals[1] = 8'h40; vals[2] = 8'h80; vals[3] = 8'hC0;

    rst = 1'b1; valid = 1'b1; din = 8'h5A; valid_s = 1'b0; din_s = 4'h0;
    bb_mode = 1'b0; last_fall = 0;
    prev_cs_n = 1'b1; prev_sclk = 1'b0; have_fall = 1'b0;
    mon_bits = 0; mon_low = 0; mon_word = '0;

    // reset held with valid high: nothing may start
    repeat (3) step();
    check("rst_ready", ready, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_frames", frames, 0);
    valid = 1'b0;
    rst   = 1'b0;
    repeat (2) step();

    // single frame 0xA5
    pulse_valid(8'hA5);
    din = 8'h00;
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    check("ready_return", n, TOT);
    repeat (3) step();
    check("frames_single", frames, 1);

    // back-to-back with valid held high
    bb_mode = 1'b1;
    din   = vals[0];
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (m_busy != TOT && n < 200);
      check("bb_accept_bound", (n < 200), 1);
      if (i < 3) din = vals[i+1];
      else valid = 1'b0;
    end
    wait_ready(n);
    repeat (3) step();
    bb_mode = 1'b0;
    check("frames_bb", frames, 5);

    // din toggling while the frame is being shifted
    pulse_valid(8'($urandom));
    for (int i = 0; i < TOT + 4; i++) begin
      din = 8'($urandom);
      step();
    end
    check("frames_bp", frames, 6);

    // mid-frame reset
    pulse_valid(8'($urandom));
    repeat (20) step();
    rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_ready", ready, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_sdata", sdata, 0);
    step();
    rst = 1'b0;
    check("midrst_frames", frames, 0);
    step();
    pulse_valid(8'h3C);
    wait_ready(n);
    check("after_rst_wait", n, TOT);
    check("frames_after_rst", frames, 1);

    // small instance: WIDTH=4, CLK_DIV=1, din=4'hC
    check("small_ready_idle", ready_s, 1);
    din_s   = 4'hC;
    valid_s = 1'b1;
    step();
    valid_s = 1'b0;
    din_s   = 4'h3;
    bits = 0; nb = 0; cs_low = 0; latch_len = 0; ready_at = 0; prev_s = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (!cs_n_s) cs_low++;
      if (cs_n_s && !ready_s) latch_len++;
      if (ready_s && ready_at == 0) ready_at = k;
      if (sclk_s && !prev_s && !cs_n_s) begin
        bits = (bits << 1) | int'(sdata_s);
        nb++;
      end
      prev_s = sclk_s;
      step();
    end
    check("small_cs_low", cs_low, 8);
    check("small_bits", bits, 32'hC);
    check("small_nbits", nb, 4);
    check("small_latch", latch_len, 1);
    check("small_ready_at", ready_at, 10);
    check("small_frames", frames_s, 1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      din   = 8'($urandom);
      step();
    end
    valid = 1'b0;
    repeat (TOT + 5) step();
    check("final_idle", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
